mmss_display_scanner: RTL and testbench

Consumer side of the mm:ss BCD digit bus. Time-multiplexes four BCD digits (m1 m2 : s1 s2) onto a common-anode 4-digit seven-segment display. Snapshots digits once per scan frame to avoid tearing, inserts an anti-ghost blanking gap between digits, and blinks the colon decimal point. Sits between the clock counter and the board display pins.

---
 rtl/mmss_disp_pkg.sv | 38 +++
 rtl/bcd_to_seg7.sv | 34 +++
 rtl/mmss_display_scanner.sv | 168 ++++++++++++++++
 tb/tb_mmss_display_scanner.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mmss_disp_pkg.sv
// ----------------------------------------------------------------------------
// mmss_disp_pkg
// Shared definitions for the mm:ss seven-segment scanner:
//   - active-low segment codes {g,f,e,d,c,b,a} for digits 0..9, dash and off
//   - all-anodes-off pattern for the 4-digit common-anode display
//   - the digit slot index type and the slot-to-digit mapping
// ----------------------------------------------------------------------------
package mmss_disp_pkg;

  typedef logic [1:0] digit_idx_t;

  // Scan order runs right to left: an[0] shows seconds ones.
  localparam digit_idx_t SLOT_S2 = 2'd0;
  localparam digit_idx_t SLOT_S1 = 2'd1;
  localparam digit_idx_t SLOT_M2 = 2'd2;
  localparam digit_idx_t SLOT_M1 = 2'd3;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] ANODES_OFF = 4'b1111;

  // Active-low one-hot anode pattern for a slot.
  function automatic logic [3:0] anode_select_n(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// ----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD to active-low seven-segment decoder. Non-BCD codes
// (10..15) show a dash so a corrupted digit is visible rather than silent.
// Ports:
//   bcd_i  [3:0]  BCD digit
//   seg_o  [6:0]  segments {g,f,e,d,c,b,a}, active-low
// ----------------------------------------------------------------------------
module bcd_to_seg7
  import mmss_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Digit lookup; anything outside 0..9 falls through to the dash.
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/mmss_display_scanner.sv
// ----------------------------------------------------------------------------
// mmss_display_scanner
// Time-multiplexes the mm:ss BCD digits onto a 4-digit common-anode
// seven-segment display. The four digits are snapshotted once per scan frame
// (at the last slot's tick) so a frame never mixes two time values. Each
// slot starts with BLANK_CYCLES of all-anodes-off to suppress ghosting, and
// the colon (dp of the m2 digit) blinks every BLINK_FRAMES frames.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   m1 [2:0], m2 [3:0], s1 [2:0], s2 [3:0]   BCD time digits
//   an  [3:0]  digit anodes, active-low, an[0] rightmost (registered)
//   seg [6:0]  segments {g,f,e,d,c,b,a}, active-low (registered)
//   dp         decimal point, active-low (registered)
// ----------------------------------------------------------------------------
module mmss_display_scanner
  import mmss_disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 125,
  parameter int LZ_BLANK     = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] m1,
  input  logic [3:0] m2,
  input  logic [2:0] s1,
  input  logic [3:0] s2,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYCLES);
  localparam logic [FR_W-1:0]  FR_LAST   = FR_W'(BLINK_FRAMES - 1);

  logic [PRE_W-1:0] pre_cnt_q,   pre_cnt_d;
  digit_idx_t       idx_q,       idx_d;
  logic [FR_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic             blink_q,     blink_d;
  logic [2:0]       snap_m1_q,   snap_m1_d;
  logic [3:0]       snap_m2_q,   snap_m2_d;
  logic [2:0]       snap_s1_q,   snap_s1_d;
  logic [3:0]       snap_s2_q,   snap_s2_d;
  logic [3:0]       an_q,        an_d;
  logic [6:0]       seg_q,       seg_d;
  logic             dp_q,        dp_d;

  logic             tick_s;
  logic             frame_end_s;
  logic [3:0]       digit_s;
  logic [6:0]       digit_seg_s;

  assign tick_s      = (pre_cnt_q == PRE_LAST);
  // Last slot of a frame is ending: the only point where new digits are
  // admitted, so every frame shows one coherent time value.
  assign frame_end_s = tick_s && (idx_q == SLOT_M1);

  // Prescaler, slot index, snapshot and blink next-state.
  always_comb begin
    pre_cnt_d   = pre_cnt_q + PRE_W'(1);
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    snap_m1_d   = snap_m1_q;
    snap_m2_d   = snap_m2_q;
    snap_s1_d   = snap_s1_q;
    snap_s2_d   = snap_s2_q;
    if (tick_s) begin
      pre_cnt_d = {PRE_W{1'b0}};
      idx_d     = idx_q + 2'd1;
    end else begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end
    if (frame_end_s) begin
      snap_m1_d = m1;
      snap_m2_d = m2;
      snap_s1_d = s1;
      snap_s2_d = s2;
      if (frame_cnt_q == FR_LAST) begin
        frame_cnt_d = {FR_W{1'b0}};
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FR_W'(1);
      end
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Pick the snapshotted digit for the current slot; 3-bit tens zero-extend.
  always_comb begin
    digit_s = snap_s2_q;
    case (idx_q)
      SLOT_S2: digit_s = snap_s2_q;
      SLOT_S1: digit_s = {1'b0, snap_s1_q};
      SLOT_M2: digit_s = snap_m2_q;
      SLOT_M1: digit_s = {1'b0, snap_m1_q};
      default: digit_s = snap_s2_q;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd_i (digit_s),
    .seg_o (digit_seg_s)
  );

  // Next output pattern from the current scan position (one-cycle latency).
  always_comb begin
    an_d  = ANODES_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (pre_cnt_q < PRE_BLANK) begin
      an_d  = ANODES_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end else begin
      an_d  = anode_select_n(idx_q);
      seg_d = digit_seg_s;
      dp_d  = ~((idx_q == SLOT_M2) && blink_q);
      // Optional leading-zero suppression keeps the minutes-tens anode dark.
      if ((LZ_BLANK != 0) && (idx_q == SLOT_M1) && (snap_m1_q == 3'd0)) begin
        an_d = ANODES_OFF;
      end else begin
        an_d = anode_select_n(idx_q);
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_q   <= {PRE_W{1'b0}};
      idx_q       <= SLOT_S2;
      frame_cnt_q <= {FR_W{1'b0}};
      blink_q     <= 1'b0;
      snap_m1_q   <= 3'd0;
      snap_m2_q   <= 4'd0;
      snap_s1_q   <= 3'd0;
      snap_s2_q   <= 4'd0;
      an_q        <= ANODES_OFF;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
      snap_m1_q   <= snap_m1_d;
      snap_m2_q   <= snap_m2_d;
      snap_s1_q   <= snap_s1_d;
      snap_s2_q   <= snap_s2_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_mmss_display_scanner.sv
// ----------------------------------------------------------------------------
// tb_mmss_display_scanner
// Scoreboard bench for the mm:ss display scanner. Two instances share the
// inputs: one without and one with leading-zero blanking. Each cycle the
// expected outputs are derived from the cycle position since reset and
// pushed to a queue; they are popped and compared after the next edge.
// ----------------------------------------------------------------------------
module tb_mmss_display_scanner;

  localparam int R  = 4;
  localparam int BL = 1;
  localparam int BF = 2;

  logic       clk;
  logic       reset;
  logic [2:0] m1;
  logic [3:0] m2;
  logic [2:0] s1;
  logic [3:0] s2;
  logic [3:0] an,    an_lz;
  logic [6:0] seg,   seg_lz;
  logic       dp,    dp_lz;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an_lz;
  } exp_t;

  exp_t       sb_q[$];
  logic [6:0] seg_tab [16];

  int vec_cnt;
  int err_cnt;
  int k;
  int sm1, sm2, ss1, ss2;

  mmss_display_scanner #(
    .REFRESH_DIV (R), .BLANK_CYCLES (BL), .BLINK_FRAMES (BF), .LZ_BLANK (0)
  ) dut (
    .clk (clk), .reset (reset), .m1 (m1), .m2 (m2), .s1 (s1), .s2 (s2),
    .an (an), .seg (seg), .dp (dp)
  );

  mmss_display_scanner #(
    .REFRESH_DIV (R), .BLANK_CYCLES (BL), .BLINK_FRAMES (BF), .LZ_BLANK (1)
  ) dut_lz (
    .clk (clk), .reset (reset), .m1 (m1), .m2 (m2), .s1 (s1), .s2 (s2),
    .an (an_lz), .seg (seg_lz), .dp (dp_lz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs,
                           input logic [15:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Expected outputs after the coming edge, then advance the model.
  task automatic push_expected(input logic rst);
    exp_t e;
    int pre, idx, frame, blink, dig;
    if (rst) begin
      e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1; e.an_lz = 4'b1111;
      k = 0; sm1 = 0; sm2 = 0; ss1 = 0; ss2 = 0;
    end else begin
      pre   = k % R;
      idx   = (k / R) % 4;
      frame = k / (4 * R);
      blink = (frame / BF) % 2;
      if (pre < BL) begin
        e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1; e.an_lz = 4'b1111;
      end else begin
        case (idx)
          0:       dig = ss2;
          1:       dig = ss1;
          2:       dig = sm2;
          default: dig = sm1;
        endcase
        e.seg   = seg_tab[dig];
        e.an    = 4'b1111;
        e.an[idx] = 1'b0;
        e.dp    = (idx == 2 && blink == 1) ? 1'b0 : 1'b1;
        e.an_lz = (idx == 3 && sm1 == 0) ? 4'b1111 : e.an;
      end
      if (k % (4 * R) == 4 * R - 1) begin
        sm1 = int'(m1); sm2 = int'(m2); ss1 = int'(s1); ss2 = int'(s2);
      end
      k++;
    end
    sb_q.push_back(e);
  endtask

  task automatic cycle(input logic rst);
    exp_t e;
    reset = rst;
    push_expected(rst);
    @(posedge clk);
    #1;
    check_val("sb_depth", 16'(sb_q.size()), 16'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("an",     {12'd0, an},     {12'd0, e.an});
      check_val("seg",    {9'd0, seg},     {9'd0, e.seg});
      check_val("dp",     {15'd0, dp},     {15'd0, e.dp});
      check_val("an_lz",  {12'd0, an_lz},  {12'd0, e.an_lz});
      check_val("seg_lz", {9'd0, seg_lz},  {9'd0, e.seg});
      check_val("dp_lz",  {15'd0, dp_lz},  {15'd0, e.dp});
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    k = 0;
    sm1 = 0; sm2 = 0; ss1 = 0; ss2 = 0;
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;

    // Reset held with non-zero inputs: outputs dark throughout.
    m1 = 3'd5; m2 = 4'd9; s1 = 3'd0; s2 = 4'd0;
    for (int i = 0; i < 3; i++) cycle(1'b1);

    // 12:34 applied at release; first frame still shows the zero snapshot.
    m1 = 3'd1; m2 = 4'd2; s1 = 3'd3; s2 = 4'd4;
    run(2 * 4 * R);

    // Change s2 mid-frame while slot 1 is active.
    while (k % (4 * R) != 5) cycle(1'b0);
    s2 = 4'd7;
    run(3 * 4 * R);

    // Boundary digits, then an invalid code with a zero minutes-tens.
    m1 = 3'd5; m2 = 4'd9; s1 = 3'd5; s2 = 4'd9;
    run(2 * 4 * R);
    m1 = 3'd0; s2 = 4'hC;
    run(2 * 4 * R);

    // One-cycle reset during slot 2 active time, then resume.
    while (k % (4 * R) != 2 * R + 2) cycle(1'b0);
    cycle(1'b1);
    run(2 * 4 * R + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
